ov7670_tx: RTL and testbench

Synthesizable OV7670 camera emulator: generates the PCLK/VSYNC/HREF/D[7:0] pixel bus that `ov7670_capture` receives, in RGB444 (xR GB) format at VGA resolution. It feeds the capture → BRAM → template/correlator path on the bench and on the board when no camera is fitted. Test patterns are selectable, including a box target for tracking tests. Runs from one clock; PCLK is derived internally.

---
 rtl/ov7670_tx_pkg.sv | 24 ++
 rtl/ov7670_tx_pattern.sv | 35 +++
 rtl/ov7670_tx.sv | 157 +++++++++++++++
 tb/tb_ov7670_tx.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/ov7670_tx_pkg.sv
// rtl/ov7670_tx_pkg.sv - shared types and RGB444 byte helper for the OV7670 emulator
package ov7670_tx_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_VSYNC,
    S_VBACK,
    S_ACTIVE,
    S_VFRONT
  } tx_state_t;

  typedef enum logic [1:0] {
    PAT_SOLID,
    PAT_RAMP,
    PAT_CHECKER,
    PAT_BOX
  } pattern_t;

  // Byte 0 of a pixel carries R in the low nibble, byte 1 carries {G, B}.
  function automatic logic [7:0] rgb444_byte(input logic [3:0] v, input logic phase);
    return phase ? {v, v} : {4'h0, v};
  endfunction

endpackage

// File: rtl/ov7670_tx_pattern.sv
// rtl/ov7670_tx_pattern.sv - maps pixel position, byte phase and latched pattern to the d byte
module ov7670_tx_pattern
  import ov7670_tx_pkg::*;
#(
  parameter int BOX_SIZE = 32
) (
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       phase,
  input  pattern_t   pattern,
  input  logic [9:0] box_x,
  input  logic [9:0] box_y,
  output logic [7:0] d
);

  logic [10:0] x_end;
  logic [10:0] y_end;
  logic        in_box;
  logic [3:0]  v;

  always_comb begin
    // 11-bit bounds so a box hanging off the right/bottom edge clips instead of wrapping.
    x_end  = {1'b0, box_x} + 11'(BOX_SIZE);
    y_end  = {1'b0, box_y} + 11'(BOX_SIZE);
    in_box = (x >= box_x) && ({1'b0, x} < x_end) && (y >= box_y) && ({1'b0, y} < y_end);
    case (pattern)
      PAT_SOLID:   v = 4'h8;
      PAT_RAMP:    v = x[7:4];
      PAT_CHECKER: v = (x[5] ^ y[5]) ? 4'hF : 4'h0;
      default:     v = in_box ? 4'hF : 4'h0;
    endcase
    d = rgb444_byte(v, phase);
  end

endmodule

// File: rtl/ov7670_tx.sv
// rtl/ov7670_tx.sv - OV7670 camera emulator top: timing FSM, PCLK/line counters, frame-start latches
// Optional OV7670_TX_MOVING_BOX_EN: box position register advances (+1,+1) after every frame.
module ov7670_tx
  import ov7670_tx_pkg::*;
#(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int H_BLANK     = 288,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10,
  parameter int BOX_SIZE    = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [9:0]  box_x,
  input  logic [9:0]  box_y,
  output logic        pclk,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  d,
  output logic        frame_done,
  output logic [15:0] frame_count,
  output logic        busy
);

  localparam logic [15:0] LINE_LAST   = 16'(2 * H_ACTIVE + H_BLANK - 1);
  localparam logic [15:0] HREF_END    = 16'(2 * H_ACTIVE);
  localparam logic [15:0] VSYNC_LAST  = 16'(VSYNC_LINES - 1);
  localparam logic [15:0] VBACK_LAST  = 16'(V_BACK - 1);
  localparam logic [15:0] ACTIVE_LAST = 16'(V_ACTIVE - 1);
  localparam logic [15:0] VFRONT_LAST = 16'(V_FRONT - 1);

  tx_state_t   state, n_state;
  logic [15:0] h_cnt, n_h;
  logic [15:0] line_cnt, n_line;
  logic [15:0] line_last;
  logic        last_frame;
  logic        start_frame;
  pattern_t    pat_q;
  logic [9:0]  box_xq, box_yq;
  logic [7:0]  pat_d;

  // Next position in the frame; registered outputs are derived from it so they
  // line up with the PCLK period that begins on this falling edge.
  always_comb begin
    n_state    = state;
    n_h        = h_cnt;
    n_line     = line_cnt;
    last_frame = 1'b0;
    case (state)
      S_VSYNC:  line_last = VSYNC_LAST;
      S_VBACK:  line_last = VBACK_LAST;
      S_ACTIVE: line_last = ACTIVE_LAST;
      default:  line_last = VFRONT_LAST;
    endcase
    if (state == S_IDLE) begin
      if (enable) begin
        n_state = S_VSYNC;
        n_h     = 16'h0;
        n_line  = 16'h0;
      end
    end else if (h_cnt == LINE_LAST) begin
      n_h = 16'h0;
      if (line_cnt == line_last) begin
        n_line = 16'h0;
        case (state)
          S_VSYNC:  n_state = S_VBACK;
          S_VBACK:  n_state = S_ACTIVE;
          S_ACTIVE: n_state = S_VFRONT;
          default: begin
            last_frame = 1'b1;
            n_state    = enable ? S_VSYNC : S_IDLE;
          end
        endcase
      end else begin
        n_line = line_cnt + 16'h1;
      end
    end else begin
      n_h = h_cnt + 16'h1;
    end
    start_frame = (n_state == S_VSYNC) && (state != S_VSYNC);
  end

  ov7670_tx_pattern #(
    .BOX_SIZE(BOX_SIZE)
  ) u_pattern (
    .x      (n_h[10:1]),
    .y      (n_line[9:0]),
    .phase  (n_h[0]),
    .pattern(pat_q),
    .box_x  (box_xq),
    .box_y  (box_yq),
    .d      (pat_d)
  );

`ifdef OV7670_TX_MOVING_BOX_EN
  function automatic logic [9:0] step_pos(input logic [9:0] p, input logic [10:0] limit);
    logic [10:0] nxt;
    nxt = {1'b0, p} + 11'd1;
    return ((nxt + 11'(BOX_SIZE)) > limit) ? 10'd0 : nxt[9:0];
  endfunction
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pclk        <= 1'b0;
      vsync       <= 1'b0;
      href        <= 1'b0;
      d           <= 8'h00;
      frame_done  <= 1'b0;
      frame_count <= 16'h0;
      busy        <= 1'b0;
      state       <= S_IDLE;
      h_cnt       <= 16'h0;
      line_cnt    <= 16'h0;
      pat_q       <= PAT_SOLID;
      box_xq      <= 10'd0;
      box_yq      <= 10'd0;
    end else begin
      pclk       <= ~pclk;
      frame_done <= 1'b0;
      // pclk high now means this edge takes it low: the only edge outputs may move on.
      if (pclk) begin
        state    <= n_state;
        h_cnt    <= n_h;
        line_cnt <= n_line;
        busy     <= (n_state != S_IDLE);
        vsync    <= (n_state == S_VSYNC);
        href     <= (n_state == S_ACTIVE) && (n_h < HREF_END);
        d        <= ((n_state == S_ACTIVE) && (n_h < HREF_END)) ? pat_d : 8'h00;
        if (last_frame) begin
          frame_done  <= 1'b1;
          frame_count <= frame_count + 16'h1;
        end
        if (start_frame) pat_q <= pattern_t'(pattern_sel);
`ifdef OV7670_TX_MOVING_BOX_EN
        if (state == S_IDLE && n_state == S_VSYNC) begin
          box_xq <= box_x;
          box_yq <= box_y;
        end else if (last_frame) begin
          box_xq <= step_pos(box_xq, 11'(H_ACTIVE));
          box_yq <= step_pos(box_yq, 11'(V_ACTIVE));
        end
`else
        if (start_frame) begin
          box_xq <= box_x;
          box_yq <= box_y;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_ov7670_tx.sv
// tb/tb_ov7670_tx.sv - self-checking bench for ov7670_tx with a pixel-byte scoreboard
module tb_ov7670_tx;

  localparam int HA = 4;
  localparam int VA = 2;
  localparam int HB = 2;
  localparam int VS = 1;
  localparam int VB = 1;
  localparam int VF = 1;
  localparam int BS = 2;
  localparam int L  = 2 * HA + HB;
  localparam int FP = (VS + VB + VA + VF) * L;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic [9:0]  box_x = 10'd0;
  logic [9:0]  box_y = 10'd0;
  logic        pclk;
  logic        vsync;
  logic        href;
  logic [7:0]  d;
  logic        frame_done;
  logic [15:0] frame_count;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int exp_frames = 0;
  logic [7:0] exp_q[$];

  ov7670_tx #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB), .VSYNC_LINES(VS),
    .V_BACK(VB), .V_FRONT(VF), .BOX_SIZE(BS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pattern_sel(pattern_sel),
    .box_x(box_x), .box_y(box_y), .pclk(pclk), .vsync(vsync), .href(href),
    .d(d), .frame_done(frame_done), .frame_count(frame_count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input int sel, input int bx, input int by);
    for (int y = 0; y < VA; y++) begin
      for (int x = 0; x < HA; x++) begin
        logic [9:0] xv;
        logic [9:0] yv;
        logic [3:0] v;
        xv = 10'(x);
        yv = 10'(y);
        case (sel)
          0:       v = 4'h8;
          1:       v = xv[7:4];
          2:       v = (xv[5] ^ yv[5]) ? 4'hF : 4'h0;
          default: v = (x >= bx && x < bx + BS && y >= by && y < by + BS) ? 4'hF : 4'h0;
        endcase
        exp_q.push_back({4'h0, v});
        exp_q.push_back({v, v});
      end
    end
  endtask

  task automatic wait_vsync_rise(input string tag);
    int n;
    n = 0;
    while (vsync !== 1'b1 && n < 2) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, vsync, 1);
  endtask

  // Entered just after the clk edge on which vsync rose; leaves just after the
  // edge that ends the frame, which is where the next vsync rises if enabled.
  task automatic run_frame(input logic en_after, input int chg_p, input int chg_sel,
                           input int chg_bx, input int chg_by, input logic chg_en);
    for (int p = 0; p < FP; p++) begin
      int ln;
      int h;
      logic ev;
      logic eh;
      logic [7:0] ed;
      @(posedge clk); #1;
      ln = p / L;
      h  = p % L;
      ev = (ln < VS);
      eh = (ln >= VS + VB) && (ln < VS + VB + VA) && (h < 2 * HA);
      if (p == 0) begin
        chk("frame_done_low", frame_done, 0);
        chk("pclk_high", pclk, 1);
      end
      chk($sformatf("vsync@%0d", p), vsync, ev);
      chk($sformatf("href@%0d", p), href, eh);
      if (eh) ed = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      else ed = 8'h00;
      chk($sformatf("d@%0d", p), d, ed);
      if (p == chg_p) begin
        pattern_sel = 2'(chg_sel);
        box_x       = 10'(chg_bx);
        box_y       = 10'(chg_by);
        enable      = chg_en;
      end
      @(posedge clk); #1;
    end
    exp_frames++;
    chk("frame_done_pulse", frame_done, 1);
    chk("frame_count", frame_count, exp_frames);
    chk("next_vsync", vsync, en_after);
    chk("busy_after_frame", busy, en_after);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pclk", pclk, 0);
    chk("rst_vsync", vsync, 0);
    chk("rst_href", href, 0);
    chk("rst_d", d, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_count", frame_count, 0);
    rst_n = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    chk("idle_vsync", vsync, 0);
    chk("idle_href", href, 0);
    chk("idle_d", d, 0);
    chk("idle_frame_done", frame_done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_frame_count", frame_count, 0);

    // Solid, box(1,0), solid with a mid-ACTIVE change to checker, then checker.
    push_frame(0, 0, 0);
    push_frame(3, 1, 0);
    push_frame(0, 0, 0);
    push_frame(2, 0, 0);
    pattern_sel = 2'd0;
    enable = 1'b1;
    wait_vsync_rise("start_latency");
    run_frame(1'b1, 5, 3, 1, 0, 1'b1);
    run_frame(1'b1, 45, 0, 1, 0, 1'b1);
    run_frame(1'b1, 25, 2, 1, 0, 1'b1);
    run_frame(1'b0, 30, 3, 2, 0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    chk("stopped_busy", busy, 0);
    chk("stopped_vsync", vsync, 0);
    chk("stopped_count", frame_count, 4);

    push_frame(3, 2, 0);
`ifdef OV7670_TX_MOVING_BOX_EN
    push_frame(3, 0, 0);
`else
    push_frame(3, 2, 0);
`endif
    enable = 1'b1;
    wait_vsync_rise("restart_latency");
    run_frame(1'b1, -1, 3, 2, 0, 1'b1);
    run_frame(1'b0, 10, 3, 2, 0, 1'b0);
    chk("scoreboard_drained", exp_q.size(), 0);

    // Asynchronous reset in ACTIVE line 1, then restart from VSYNC.
    repeat (6) @(posedge clk);
    #1;
    pattern_sel = 2'd0;
    enable = 1'b1;
    wait_vsync_rise("pre_reset_start");
    repeat (2 * 33 + 1) @(posedge clk);
    #1;
    chk("pre_reset_href", href, 1);
    chk("pre_reset_d", d, 8'h88);
    rst_n = 1'b0;
    #1;
    chk("async_rst_href", href, 0);
    chk("async_rst_d", d, 0);
    chk("async_rst_vsync", vsync, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_pclk", pclk, 0);
    chk("async_rst_count", frame_count, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_vsync_rise("post_reset_latency");
    chk("post_reset_busy", busy, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
